// File: rtl/risc_ctrl_seq.sv
// Eight-phase instruction-cycle sequencer for the 8-bit RISC core: decodes the
// phase, opcode and ALU zero flag into datapath strobes, with a sticky halt.
module risc_ctrl_seq #(
    parameter int unsigned OPW  = 3,
    parameter int unsigned PH_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [OPW-1:0]  opcd,
    input  logic            zr,
    output logic            sel,
    output logic            rd,
    output logic            ld_ir,
    output logic            inc_pc,
    output logic            ld_pc,
    output logic            halt,
    output logic            data_e,
    output logic            ld_ac,
    output logic            wr,
    output logic [PH_W-1:0] phase
);

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_t;

    typedef enum logic [2:0] {
        OP_HLT = 3'b000,
        OP_SKZ = 3'b001,
        OP_ADD = 3'b010,
        OP_AND = 3'b011,
        OP_XOR = 3'b100,
        OP_LDA = 3'b101,
        OP_STO = 3'b110,
        OP_JMP = 3'b111
    } opcode_t;

    phase_t r_phase;
    phase_t w_phase_nxt;
    logic   r_halted;
    logic   w_halted_nxt;

    logic   w_hlt;
    logic   w_skz;
    logic   w_aluop;
    logic   w_sto;
    logic   w_jmp;

    // Unknown opcodes fall into default and raise no opcode-specific strobe.
    always_comb begin
        w_hlt   = 1'b0;
        w_skz   = 1'b0;
        w_aluop = 1'b0;
        w_sto   = 1'b0;
        w_jmp   = 1'b0;
        case (opcd)
            OP_HLT:                         w_hlt   = 1'b1;
            OP_SKZ:                         w_skz   = 1'b1;
            OP_ADD, OP_AND, OP_XOR, OP_LDA: w_aluop = 1'b1;
            OP_STO:                         w_sto   = 1'b1;
            OP_JMP:                         w_jmp   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase  <= PH_INST_ADDR;
            r_halted <= 1'b0;
        end else begin
            r_phase  <= w_phase_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    // Halting parks the phase at OP_ADDR instead of advancing.
    always_comb begin
        w_phase_nxt  = r_phase;
        w_halted_nxt = r_halted;
        if (en && !r_halted) begin
            if (r_phase == PH_OP_ADDR && w_hlt)
                w_halted_nxt = 1'b1;
            else
                w_phase_nxt = phase_t'(r_phase + 3'd1);
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        data_e = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        case (r_phase)
            PH_INST_ADDR: begin
                sel = 1'b1;
            end
            PH_INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            PH_INST_LOAD, PH_IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            PH_OP_ADDR: begin
                inc_pc = 1'b1;
            end
            PH_OP_FETCH: begin
                rd = w_aluop;
            end
            PH_ALU_OP: begin
                rd     = w_aluop;
                inc_pc = w_skz && zr;
                ld_pc  = w_jmp;
                data_e = w_sto;
            end
            PH_STORE: begin
                rd     = w_aluop;
                ld_ac  = w_aluop;
                inc_pc = w_jmp;
                ld_pc  = w_jmp;
                wr     = w_sto;
                data_e = w_sto;
            end
            default: ;
        endcase
    end

    assign halt  = r_halted || (r_phase == PH_OP_ADDR && w_hlt);
    assign phase = r_phase;

    a_opcd_known: assert property (@(posedge clk) disable iff (rst)
        (r_phase inside {PH_OP_ADDR, PH_OP_FETCH, PH_ALU_OP, PH_STORE}) |-> !$isunknown(opcd));

endmodule

// File: tb/tb_risc_ctrl_seq.sv
// Scoreboard bench for risc_ctrl_seq: a cycle-level reference model queues the
// expected strobe vector for every cycle; a negedge monitor pops and compares.
module tb_risc_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] opcd;
    logic       zr;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr;
    logic [2:0] phase;

    always #5 clk = ~clk;

    risc_ctrl_seq #(.OPW(3), .PH_W(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .opcd   (opcd),
        .zr     (zr),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .halt   (halt),
        .data_e (data_e),
        .ld_ac  (ld_ac),
        .wr     (wr),
        .phase  (phase)
    );

    int          errors = 0;
    int          checks = 0;
    string       q_tag[$];
    logic [11:0] q_exp[$];

    int    m_phase  = 0;
    bit    m_halted = 1'b0;
    bit    m_valid  = 1'b0;
    string cur_tag  = "reset";

    // Vector order: sel rd ld_ir inc_pc ld_pc halt data_e ld_ac wr phase[2:0]
    function automatic logic [11:0] model(input int ph, input bit hl,
                                          input logic [2:0] op, input logic z);
        bit aluop, sto, jmp, skz, hlt;
        bit e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_halt, e_de, e_ldac, e_wr;
        logic [2:0] ph3;
        aluop  = (op >= 3'd2 && op <= 3'd5);
        sto    = (op == 3'd6);
        jmp    = (op == 3'd7);
        skz    = (op == 3'd1);
        hlt    = (op == 3'd0);
        e_sel  = (ph <= 3);
        e_rd   = (ph >= 1 && ph <= 3) || (ph >= 5 && aluop);
        e_ldir = (ph == 2 || ph == 3);
        e_inc  = (ph == 4) || (ph == 6 && skz && z) || (ph == 7 && jmp);
        e_ldpc = (ph >= 6) && jmp;
        e_halt = hl || (ph == 4 && hlt);
        e_de   = (ph >= 6) && sto;
        e_ldac = (ph == 7) && aluop;
        e_wr   = (ph == 7) && sto;
        ph3    = 3'(ph);
        return {e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_halt, e_de, e_ldac, e_wr, ph3};
    endfunction

    // Called just after a rising edge: drive inputs, queue the expectation for
    // this cycle, advance the model across the coming edge, then wait for it.
    task automatic step(input logic r, input logic e, input logic [2:0] op, input logic z);
        rst  = r;
        en   = e;
        opcd = op;
        zr   = z;
        if (m_valid) begin
            q_tag.push_back(cur_tag);
            q_exp.push_back(model(m_phase, m_halted, op, z));
        end
        if (r) begin
            m_phase  = 0;
            m_halted = 1'b0;
            m_valid  = 1'b1;
        end else if (m_valid && e && !m_halted) begin
            if (m_phase == 4 && op == 3'd0) m_halted = 1'b1;
            else                            m_phase  = (m_phase + 1) % 8;
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [11:0] act, exp;
        string       tag;
        while (q_exp.size() > 0) begin
            exp = q_exp.pop_front();
            tag = q_tag.pop_front();
            act = {sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr, phase};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL %s: got %b required %b (sel rd ld_ir inc_pc ld_pc halt data_e ld_ac wr phase)",
                         tag, act, exp);
            end
            checks++;
            if ((wr && !data_e) || (ld_ir && !rd) || (wr && rd) || (ld_pc && opcd != 3'd7)) begin
                errors++;
                $display("FAIL %s_invariant: got wr=%b data_e=%b ld_ir=%b rd=%b ld_pc=%b opcd=%b required exclusive strobes",
                         tag, wr, data_e, ld_ir, rd, ld_pc, opcd);
            end
        end
    end

    initial begin
        logic [2:0] rop;
        logic       rr, re;
        rst  = 1'b1;
        en   = 1'b0;
        opcd = 3'd2;
        zr   = 1'b0;
        @(posedge clk);
        #1;

        cur_tag = "reset";
        step(1'b1, 1'b1, 3'd2, 1'b0);
        step(1'b1, 1'b1, 3'd2, 1'b0);

        cur_tag = "add";
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 3'd2, 1'b0);
        cur_tag = "sto";
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'd6, 1'b0);
        cur_tag = "skz_z1";
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'd1, 1'b1);
        cur_tag = "skz_z0";
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'd1, 1'b0);
        cur_tag = "jmp";
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'd7, 1'b0);
        cur_tag = "lda_and_xor";
        for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 3'(3 + i / 8), 1'b0);

        cur_tag = "stall_seek";
        for (int i = 0; i < 16 && m_phase != 2; i++) step(1'b0, 1'b1, 3'd2, 1'b0);
        cur_tag = "stall";
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd2, 1'b0);
        cur_tag = "stall_release";
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'd2, 1'b0);

        cur_tag = "hlt_seek";
        for (int i = 0; i < 16 && !m_halted; i++) step(1'b0, 1'b1, 3'd0, 1'b0);
        cur_tag = "halted";
        for (int i = 0; i < 20; i++) step(1'b0, 1'(i % 2), 3'd0, 1'(i % 3 == 0));
        cur_tag = "halt_rst";
        step(1'b1, 1'b1, 3'd0, 1'b0);
        cur_tag = "after_halt";
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'd2, 1'b0);

        cur_tag = "random";
        rop = 3'd2;
        for (int i = 0; i < 3000; i++) begin
            if (m_phase < 3 && $urandom_range(3) == 0) rop = 3'($urandom_range(7));
            rr = ($urandom_range(63) == 0);
            re = ($urandom_range(3) != 0);
            step(rr, re, rop, 1'($urandom_range(1)));
        end

        @(negedge clk);
        #1;
        checks++;
        if (q_exp.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", q_exp.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
